// File: rtl/can_bit_timer.sv
// CAN bit-timing generator: runtime prescaler into time quanta, SYNC/SEG1/SEG2
// segment sequencer with hard sync and SJW-limited resynchronisation.
module can_bit_timer #(
   parameter int BRP_W  = 6,
   parameter int SEG1_W = 4,
   parameter int SEG2_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [BRP_W-1:0]  brp,
   input  logic [SEG1_W-1:0] tseg1,
   input  logic [SEG2_W-1:0] tseg2,
   input  logic [1:0]        sjw,
   input  logic              hard_sync,
   input  logic              resync_edge,
   output logic              tq_tick,
   output logic              tq_clk,
   output logic              bit_start,
   output logic              sample_point,
   output logic [1:0]        seg
);

   localparam int Q_W = ((SEG1_W > SEG2_W) ? SEG1_W : SEG2_W) + 1;
   localparam int QX  = Q_W + 1;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_SEG1 = 2'd1,
      ST_SEG2 = 2'd2
   } state_t;

   state_t            state;
   logic [BRP_W-1:0]  brp_q;
   logic [SEG1_W-1:0] tseg1_q;
   logic [SEG2_W-1:0] tseg2_q;
   logic [1:0]        sjw_q;
   logic [BRP_W-1:0]  pcnt;
   logic [BRP_W-1:0]  pcnt_nx;
   logic [Q_W-1:0]    qcnt;
   logic [SEG1_W:0]   seg1_lim;
   logic [SEG2_W:0]   seg2_lim;
   logic              rsync_done;

   logic              tick;
   logic              edge_ok;
   logic [QX-1:0]     sjw1;
   logic [QX-1:0]     q1;
   logic [QX-1:0]     r;
   logic [QX-1:0]     lim1_x;
   logic [QX-1:0]     lim2_x;
   logic              seg1_end;
   logic              seg2_end;

   // Resync edges only count while the timer runs; a coincident tick
   // is decided against the already-adjusted segment limit.
   always_comb begin
      tick    = en & ~rst & (pcnt == brp_q);
      edge_ok = resync_edge & en & ~hard_sync & ~rsync_done & (state != ST_SYNC);
      sjw1    = QX'(sjw_q) + QX'(1);
      q1      = QX'(qcnt) + QX'(1);
      r       = QX'(seg2_lim) - QX'(qcnt);
      lim1_x  = QX'(seg1_lim);
      lim2_x  = QX'(seg2_lim);
      if (edge_ok && state == ST_SEG1)
         lim1_x = lim1_x + ((q1 < sjw1) ? q1 : sjw1);
      if (edge_ok && state == ST_SEG2)
         lim2_x = (r <= sjw1) ? q1 : (lim2_x - sjw1);
      seg1_end = (QX'(qcnt) == lim1_x - QX'(1));
      seg2_end = (QX'(qcnt) == lim2_x - QX'(1));

      pcnt_nx = pcnt;
      if (rst || hard_sync)
         pcnt_nx = '0;
      else if (en)
         pcnt_nx = tick ? '0 : pcnt + BRP_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_SYNC;
         pcnt         <= '0;
         qcnt         <= '0;
         seg1_lim     <= '0;
         seg2_lim     <= '0;
         rsync_done   <= 1'b0;
         bit_start    <= 1'b0;
         sample_point <= 1'b0;
         tq_clk       <= 1'b1;
         brp_q        <= brp;
         tseg1_q      <= tseg1;
         tseg2_q      <= tseg2;
         sjw_q        <= sjw;
      end else if (hard_sync) begin
         state        <= ST_SYNC;
         pcnt         <= '0;
         qcnt         <= '0;
         rsync_done   <= 1'b0;
         bit_start    <= 1'b1;
         sample_point <= 1'b0;
         tq_clk       <= 1'b1;
         brp_q        <= brp;
         tseg1_q      <= tseg1;
         tseg2_q      <= tseg2;
         sjw_q        <= sjw;
      end else begin
         bit_start    <= 1'b0;
         sample_point <= 1'b0;
         tq_clk       <= (pcnt_nx <= (brp_q >> 1));
         if (en) begin
            pcnt     <= pcnt_nx;
            seg1_lim <= lim1_x[SEG1_W:0];
            seg2_lim <= lim2_x[SEG2_W:0];
            if (edge_ok)
               rsync_done <= 1'b1;
            if (tick) begin
               case (state)
                  ST_SYNC: begin
                     state    <= ST_SEG1;
                     qcnt     <= '0;
                     seg1_lim <= (SEG1_W+1)'(tseg1_q) + (SEG1_W+1)'(1);
                     seg2_lim <= (SEG2_W+1)'(tseg2_q) + (SEG2_W+1)'(1);
                  end
                  ST_SEG1: begin
                     if (seg1_end) begin
                        state        <= ST_SEG2;
                        qcnt         <= '0;
                        sample_point <= 1'b1;
                     end else begin
                        qcnt <= qcnt + Q_W'(1);
                     end
                  end
                  ST_SEG2: begin
                     if (seg2_end) begin
                        state      <= ST_SYNC;
                        qcnt       <= '0;
                        rsync_done <= 1'b0;
                        bit_start  <= 1'b1;
                        brp_q      <= brp;
                        tseg1_q    <= tseg1;
                        tseg2_q    <= tseg2;
                        sjw_q      <= sjw;
                     end else begin
                        qcnt <= qcnt + Q_W'(1);
                     end
                  end
                  default: state <= ST_SYNC;
               endcase
            end
         end
      end
   end

   assign tq_tick = tick;
   assign seg     = state;

endmodule
